// File: rtl/ysyx_23060332_lsu_if.sv
// EXU/WBU/memory bundle for the load-store unit.
// The LSU takes the slave side; its environment takes the master side.
interface ysyx_23060332_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        mem_wen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_wen,
    input  req_addr,
    input  req_wdata,
    input  req_size,
    input  req_signed,
    input  req_rd,
    output rsp_valid,
    input  rsp_ready,
    output rsp_rdata,
    output rsp_rd,
    output rsp_err,
    output mem_wen,
    output mem_raddr,
    output mem_waddr,
    output mem_wdata,
    output mem_wmask,
    input  mem_rdata
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req_wen,
    output req_addr,
    output req_wdata,
    output req_size,
    output req_signed,
    output req_rd,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_rdata,
    input  rsp_rd,
    input  rsp_err,
    input  mem_wen,
    input  mem_raddr,
    input  mem_waddr,
    input  mem_wdata,
    input  mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/ysyx_23060332_lsu.sv
// Load-store unit: one request at a time, fixed-latency word memory,
// byte-lane store formatting and sign/zero-extended load extraction.
module ysyx_23060332_lsu #(
  parameter int LAT = 1
) (
  input logic clk,
  input logic rst,
  ysyx_23060332_lsu_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wen_q;
  logic          sgn_q;
  logic [1:0]    size_q;
  logic [1:0]    a_q;

  logic          bad;
  logic [7:0]    st_mask;
  logic [31:0]   st_data;
  logic [31:0]   sh;
  logic [31:0]   ld_data;

  assign bus.req_ready = (state == IDLE);

  always_comb begin
    bad = 1'b0;
    st_mask = 8'h0F;
    st_data = bus.req_wdata;
    unique case (1'b1)
      bus.req_size == 2'b00: begin
        st_mask = 8'h01 << bus.req_addr[1:0];
        st_data = {4{bus.req_wdata[7:0]}};
      end
      bus.req_size == 2'b01: begin
        bad = bus.req_addr[0];
        st_mask = 8'h03 << bus.req_addr[1:0];
        st_data = {2{bus.req_wdata[15:0]}};
      end
      bus.req_size == 2'b10: begin
        bad = |bus.req_addr[1:0];
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    sh = bus.mem_rdata >> {a_q, 3'b000};
    ld_data = bus.mem_rdata;
    unique case (1'b1)
      size_q == 2'b00: begin
        ld_data = sgn_q ? {{24{sh[7]}}, sh[7:0]}
                        : {24'h0, sh[7:0]};
      end
      size_q == 2'b01: begin
        ld_data = sgn_q ? {{16{sh[15]}}, sh[15:0]}
                        : {16'h0, sh[15:0]};
      end
      default: begin
        ld_data = bus.mem_rdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wen_q         <= 1'b0;
      sgn_q         <= 1'b0;
      size_q        <= 2'b00;
      a_q           <= 2'b00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_rd    <= 5'h0;
      bus.mem_wen   <= 1'b0;
      bus.mem_raddr <= 32'h0;
      bus.mem_waddr <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.mem_wmask <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wen_q      <= bus.req_wen;
            sgn_q      <= bus.req_signed;
            size_q     <= bus.req_size;
            a_q        <= bus.req_addr[1:0];
            bus.rsp_rd <= bus.req_rd;
            if (bad) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'h0;
            end else begin
              state         <= WAIT;
              cnt           <= CW'(LAT - 1);
              bus.rsp_err   <= 1'b0;
              bus.mem_raddr <= {bus.req_addr[31:2], 2'b00};
              bus.mem_waddr <= {bus.req_addr[31:2], 2'b00};
              bus.mem_wdata <= st_data;
              bus.mem_wmask <= st_mask;
              bus.mem_wen   <= bus.req_wen && (LAT == 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= wen_q ? 32'h0 : ld_data;
            bus.mem_wen   <= 1'b0;
            bus.mem_raddr <= 32'h0;
            bus.mem_waddr <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_wmask <= 8'h0;
          end else begin
            cnt         <= cnt - CW'(1);
            // strobe is registered, so raise it one cycle ahead of cnt==0
            bus.mem_wen <= wen_q && (cnt == CW'(1));
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Bench for ysyx_23060332_lsu: LAT=1 and LAT=3 units against
// a byte-level reference memory and load/store model.
module tb_ysyx_23060332_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  rv = '0;
  logic [1:0]  rr = '0;
  logic        wen = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = '0;
  logic        sgn = 1'b0;
  logic [4:0]  rd = '0;

  logic [1:0]  o_ready;
  logic [1:0]  o_valid;
  logic [1:0]  o_err;
  logic [1:0]  o_wen;
  logic [31:0] o_rdata [2];
  logic [4:0]  o_rd [2];
  logic [31:0] o_raddr [2];
  logic [31:0] o_waddr [2];
  logic [31:0] o_wdata [2];
  logic [7:0]  o_wmask [2];

  logic [31:0] mem [2][16];
  logic [31:0] refm [2][16];

  int n_chk = 0;
  int n_fail = 0;

  ysyx_23060332_lsu_if b [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_u
    assign b[g].req_valid  = rv[g];
    assign b[g].rsp_ready  = rr[g];
    assign b[g].req_wen    = wen;
    assign b[g].req_addr   = addr;
    assign b[g].req_wdata  = wdata;
    assign b[g].req_size   = size;
    assign b[g].req_signed = sgn;
    assign b[g].req_rd     = rd;
    assign b[g].mem_rdata  = mem[g][b[g].mem_raddr[5:2]];
    assign o_ready[g] = b[g].req_ready;
    assign o_valid[g] = b[g].rsp_valid;
    assign o_err[g]   = b[g].rsp_err;
    assign o_wen[g]   = b[g].mem_wen;
    assign o_rdata[g] = b[g].rsp_rdata;
    assign o_rd[g]    = b[g].rsp_rd;
    assign o_raddr[g] = b[g].mem_raddr;
    assign o_waddr[g] = b[g].mem_waddr;
    assign o_wdata[g] = b[g].mem_wdata;
    assign o_wmask[g] = b[g].mem_wmask;
    ysyx_23060332_lsu #(.LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(b[g])
    );
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      if (o_wen[u])
        for (int j = 0; j < 4; j++)
          if (o_wmask[u][j])
            mem[u][o_waddr[u][5:2]][8*j +: 8] <= o_wdata[u][8*j +: 8];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input int u);
    chk("z_valid", 32'(o_valid[u]), 0);
    chk("z_err", 32'(o_err[u]), 0);
    chk("z_rdata", o_rdata[u], 0);
    chk("z_rd", 32'(o_rd[u]), 0);
    chk("z_wen", 32'(o_wen[u]), 0);
    chk("z_raddr", o_raddr[u], 0);
    chk("z_waddr", o_waddr[u], 0);
    chk("z_wdata", o_wdata[u], 0);
    chk("z_wmask", 32'(o_wmask[u]), 0);
    chk("z_ready", 32'(o_ready[u]), 1);
  endtask

  task automatic run(input int u, input logic w,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input logic [1:0] sz, input logic sg,
                     input logic [4:0] r, input int hold,
                     input logic poke, input logic rst_mid);
    int lat, n, a, idx;
    logic err;
    longint v, lim;
    logic [31:0] e_rd, e_data, w_al;
    logic [7:0] e_mask;
    lat = (u == 0) ? 1 : 3;
    a = int'(ad[1:0]);
    idx = int'(ad[5:2]);
    n = (sz == 2'b11) ? 1 : (1 << sz);
    err = (sz == 2'b11) || (n == 2 && a % 2 != 0) || (n == 4 && a != 0);
    w_al = ad & 32'hFFFF_FFFC;
    e_mask = 8'(((1 << n) - 1) << a);
    for (int j = 0; j < 4; j++)
      e_data[8*j +: 8] = wd[8*(j % n) +: 8];
    v = longint'(refm[u][idx]);
    if (n < 4) begin
      lim = longint'(1) << (8 * n);
      v = (v >> (8 * a)) % lim;
      if (sg && v >= lim / 2) v = v - lim;
    end
    e_rd = (err || w) ? 32'h0 : 32'(v);

    wen = w; addr = ad; wdata = wd; size = sz; sgn = sg; rd = r;
    rv[u] = 1'b1;
    #1 chk("rdy_idle", 32'(o_ready[u]), 1);
    @(posedge clk); #1;
    rv[u] = 1'b0;
    if (!err) begin
      for (int k = 0; k < lat; k++) begin
        chk("raddr", o_raddr[u], w_al);
        chk("waddr", o_waddr[u], w_al);
        chk("wen", 32'(o_wen[u]), 32'(w && k == lat - 1));
        chk("w_valid", 32'(o_valid[u]), 0);
        chk("w_ready", 32'(o_ready[u]), 0);
        if (w && k == lat - 1) begin
          chk("wmask", 32'(o_wmask[u]), 32'(e_mask));
          chk("wdata", o_wdata[u], e_data);
        end
        if (rst_mid && k == 1) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          chk_zero(u);
          return;
        end
        @(posedge clk); #1;
      end
      if (w)
        for (int i = 0; i < n; i++)
          refm[u][idx][8*(a + i) +: 8] = wd[8*i +: 8];
    end
    for (int h = 0; h <= hold; h++) begin
      chk("r_valid", 32'(o_valid[u]), 1);
      chk("r_err", 32'(o_err[u]), 32'(err));
      chk("r_rdata", o_rdata[u], e_rd);
      chk("r_rd", 32'(o_rd[u]), 32'(r));
      chk("r_wen", 32'(o_wen[u]), 0);
      chk("r_ready", 32'(o_ready[u]), 0);
      if (h < hold) begin
        if (poke) begin
          rv[u] = 1'b1;
          wen = 1'b0;
          addr = $urandom;
          size = 2'(2 - (addr[1:0] == 0 ? 0 : 2));
          rd = 5'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    rr[u] = 1'b1;
    @(posedge clk); #1;
    rr[u] = 1'b0;
    rv[u] = 1'b0;
    chk("done_valid", 32'(o_valid[u]), 0);
    chk("done_ready", 32'(o_ready[u]), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ad;
    logic [1:0] sz;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) begin
        mem[u][i] = $urandom;
        refm[u][i] = mem[u][i];
      end
    mem[0][1] = 32'h8899AABB;
    refm[0][1] = 32'h8899AABB;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 0, 32'h8000_0005, 0, 2'b00, 1, 5'd3, 0, 0, 0);
    run(0, 0, 32'h8000_0006, 0, 2'b01, 0, 5'd4, 0, 0, 0);
    run(0, 0, 32'h8000_0004, 0, 2'b10, 0, 5'd5, 0, 0, 0);
    run(0, 1, 32'h8000_0003, 32'h1234_56EF, 2'b00, 0, 5'd6, 0, 0, 0);
    chk("st_mem", mem[0][0][31:24], 32'hEF);
    run(0, 0, 32'h8000_0002, 0, 2'b10, 0, 5'd7, 0, 0, 0);
    run(0, 1, 32'h8000_0008, 32'hDEAD_BEEF, 2'b11, 0, 5'd8, 0, 0, 0);
    run(1, 1, 32'h8000_0002, 32'h0000_CAFE, 2'b01, 0, 5'd9, 0, 0, 0);
    run(1, 1, 32'h8000_0012, 32'h0000_5A5A, 2'b01, 0, 5'd10, 0, 0, 1);
    run(1, 0, 32'h8000_0010, 0, 2'b10, 0, 5'd11, 0, 0, 0);
    run(0, 0, 32'h8000_0005, 0, 2'b00, 0, 5'd12, 5, 1, 0);
    run(0, 0, 32'h8000_0004, 0, 2'b10, 0, 5'd13, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      ad = 32'h8000_0000 | 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      run(t % 2, 1'($urandom), ad, $urandom, sz, 1'($urandom),
          5'($urandom), $urandom_range(0, 3), 1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
